slot_reel_engine: RTL
=====================

SLOT_REEL_ENGINE -- requirements
Module: slot_reel_engine

Interface
REQ-001 SHALL have parameter NUM_REELS, default 3, number of independent reels (1..8).
REQ-002 SHALL have parameter SYM_W, default 4, symbol width in bits per reel.
REQ-003 SHALL have parameter SYM_MAX, default 9, highest symbol value (0..2^SYM_W-1).
REQ-004 SHALL have parameter BASE_DIV, default 4, clock cycles per advance of reel 0 (>=2).
REQ-005 SHALL have parameter STEP_DIV, default 2, extra cycles per advance added for each higher reel index.
REQ-006 SHALL have parameter AUTO_CYC, default 1000, auto-stop timeout in cycles (used only with SLOT_AUTOSTOP_EN).
REQ-007 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port gameselect  input  1  synchronous level; a rising edge starts a game.
REQ-010 SHALL have port btn2  input  1  synchronous level; a rising edge stops the next spinning reel.
REQ-011 SHALL have port reel_sym  output  NUM_REELS*SYM_W  current symbols; reel i at bits [i*SYM_W +: SYM_W].
REQ-012 SHALL have port spinning  output  NUM_REELS  bit i high while reel i advances.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the last reel stops.
REQ-014 SHALL have port win  output  1  high when all reels show equal symbols after a game.

Function
REQ-015 SHALL implement FSM states IDLE, SPIN, RESULT; IDLE->SPIN on gameselect edge; SPIN->RESULT when last reel stops; RESULT->IDLE after exactly one cycle.
REQ-016 SHALL detect edges internally via one register per input; an edge is current=1 and previous=0.
REQ-017 On SPIN entry SHALL set all spinning bits, clear all prescalers to 0, clear win, and keep reel symbols from the previous game.
REQ-018 Reel i SHALL use divisor DIV_i = BASE_DIV + i*STEP_DIV; its prescaler counts 0..DIV_i-1, and the reel advances in the cycle the prescaler equals DIV_i-1.
REQ-019 Reel advance SHALL wrap SYM_MAX to 0; otherwise it increments by 1.
REQ-020 Each btn2 edge in SPIN SHALL clear spinning for the lowest-index reel still spinning; reels stop strictly in index order.
REQ-021 If a stop and an advance land in the same cycle, the stop SHALL take priority and the reel SHALL hold its pre-advance value.
REQ-022 In the cycle the last reel stops, SHALL register win = (all reel_sym fields equal) and enter RESULT; done SHALL be 1 only in RESULT.
REQ-023 win SHALL hold until the next SPIN entry.
REQ-024 A gameselect edge outside IDLE SHALL be ignored; a btn2 edge outside SPIN SHALL be ignored.
REQ-025 Simultaneous gameselect and btn2 edges in IDLE SHALL start the game and discard the stop.
REQ-026 With NUM_REELS=1, win SHALL be 1 at every game end.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, all reel_sym to 0, spinning 0, done 0, win 0, prescalers and edge registers 0.
REQ-028 Reset asserted mid-SPIN SHALL abort the game with no done pulse; on release the block SHALL wait in IDLE.

Configuration
REQ-029 With macro SLOT_AUTOSTOP_EN defined, a timeout counter SHALL run in SPIN, clear on SPIN entry and on every stop, and when it reaches AUTO_CYC-1 SHALL act as a btn2 edge (same priority rules) and then clear.
REQ-030 Without SLOT_AUTOSTOP_EN, no timeout logic SHALL exist, AUTO_CYC SHALL be unused, and reels SHALL stop only on btn2.

Verification
REQ-031 Defaults; reset, gameselect edge, then 24 cycles in SPIN -> reel_sym = {3,4,6} (reel2,reel1,reel0), spinning=3'b111.
REQ-032 Defaults; three btn2 edges 10 cycles apart -> spinning 110, 100, 000 in order; done pulses exactly 1 cycle; state returns to IDLE.
REQ-033 Force stops so reels all read 5 -> win=1 after done, win stays 1 in IDLE, clears on next gameselect edge; unequal reels -> win=0.
REQ-034 btn2 edge in the cycle reel0 prescaler=3 holding symbol 9 -> reel0 stays 9 (no wrap to 0).
REQ-035 rst_n low mid-SPIN -> all outputs 0 at once, no done; gameselect+btn2 edges together in IDLE -> SPIN with all three reels spinning.
REQ-036 SLOT_AUTOSTOP_EN, AUTO_CYC=50, no btn2 -> reels stop at 50, 100, 150 cycles after SPIN entry; done at cycle 151.

Source files
------------

// File: rtl/slot_reel_engine.sv
`default_nettype none
// ============================================================================
// Module   : slot_reel_engine
// Purpose  : Multi-reel slot machine core with start/stop edge control and a
//            win flag. Optional auto-stop timeout via macro SLOT_AUTOSTOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module slot_reel_engine #(
    parameter int NUM_REELS = 3,
    parameter int SYM_W     = 4,
    parameter int SYM_MAX   = 9,
    parameter int BASE_DIV  = 4,
    parameter int STEP_DIV  = 2,
    parameter int AUTO_CYC  = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       gameselect,
    input  logic                       btn2,
    output logic [NUM_REELS*SYM_W-1:0] reel_sym,
    output logic [NUM_REELS-1:0]       spinning,
    output logic                       done,
    output logic                       win
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_spin   = 2'd1;
    localparam logic [1:0] c_st_result = 2'd2;

    localparam int               c_div_max = BASE_DIV + (NUM_REELS - 1) * STEP_DIV;
    localparam int               c_presc_w = (c_div_max > 2) ? $clog2(c_div_max) : 1;
    localparam logic [SYM_W-1:0] c_sym_max = SYM_W'(SYM_MAX);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 r_gs_prev;
    logic                 r_btn_prev;
    logic                 w_gs_edge;
    logic                 w_btn_edge;
    logic                 w_start;
    logic                 w_timeout;
    logic                 w_stop;
    logic [NUM_REELS-1:0] w_stop_mask;
    logic [NUM_REELS-1:0] w_stop_clr;
    logic                 w_last_stop;
    logic                 w_all_equal;
    logic [NUM_REELS-1:0] r_spinning;
    logic                 r_win;

    assign w_gs_edge  = gameselect & ~r_gs_prev;
    assign w_btn_edge = btn2 & ~r_btn_prev;
    assign w_start    = (r_state == c_st_idle) & w_gs_edge;
    assign w_stop     = (r_state == c_st_spin) & (w_btn_edge | w_timeout);

    // Reels stop in index order, so the target is the lowest set spinning bit.
    assign w_stop_mask = r_spinning & (~r_spinning + NUM_REELS'(1));
    assign w_stop_clr  = w_stop ? w_stop_mask : '0;
    assign w_last_stop = w_stop & (r_spinning == w_stop_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gs_prev  <= 1'b0;
            r_btn_prev <= 1'b0;
        end else begin
            r_gs_prev  <= gameselect;
            r_btn_prev <= btn2;
        end
    end

`ifdef SLOT_AUTOSTOP_EN
    localparam int c_auto_w = $clog2(AUTO_CYC + 1);

    logic [c_auto_w-1:0] r_auto_cnt;

    assign w_timeout = (r_state == c_st_spin) && (r_auto_cnt == c_auto_w'(AUTO_CYC - 1));

    // Restarts on every stop so each reel gets a full timeout window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= '0;
        end else if ((r_state != c_st_spin) || w_stop) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + c_auto_w'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:   if (w_gs_edge)   w_next_state = c_st_spin;
            c_st_spin:   if (w_last_stop) w_next_state = c_st_result;
            c_st_result: w_next_state = c_st_idle;
            default:     w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        done = 1'b0;
        if (r_state == c_st_result) begin
            done = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spinning <= '0;
            r_win      <= 1'b0;
        end else if (w_start) begin
            r_spinning <= '1;
            r_win      <= 1'b0;
        end else begin
            r_spinning <= r_spinning & ~w_stop_clr;
            if (w_last_stop) begin
                r_win <= w_all_equal;
            end
        end
    end

    // Stopped reels already hold their final value, so comparing the current
    // registers gives the end-of-game picture.
    always_comb begin
        w_all_equal = 1'b1;
        for (int i = 1; i < NUM_REELS; i++) begin
            if (reel_sym[i*SYM_W +: SYM_W] != reel_sym[SYM_W-1:0]) begin
                w_all_equal = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
        localparam int c_div = BASE_DIV + g * STEP_DIV;

        logic [c_presc_w-1:0] r_presc;
        logic [SYM_W-1:0]     r_sym;

        // A stop landing on the advance cycle wins: the symbol is frozen as-is.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_presc <= '0;
                r_sym   <= '0;
            end else if (w_start) begin
                r_presc <= '0;
            end else if ((r_state == c_st_spin) && r_spinning[g] && !w_stop_clr[g]) begin
                if (r_presc == c_presc_w'(c_div - 1)) begin
                    r_presc <= '0;
                    r_sym   <= (r_sym == c_sym_max) ? '0 : r_sym + SYM_W'(1);
                end else begin
                    r_presc <= r_presc + c_presc_w'(1);
                end
            end
        end

        assign reel_sym[g*SYM_W +: SYM_W] = r_sym;
    end

    assign spinning = r_spinning;
    assign win      = r_win;

endmodule
`default_nettype wire
